mc_main_fsm: RTL and testbench
==============================

MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles each memory state is held; legal range 1..15.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 opcode  input  7  instr[6:0] from the instruction register; stable from Decode until the next Fetch.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 alu_op  output  2  ALUOp to the ALU decoder: 00 add, 01 sub, 10 funct-decoded.
REQ-007 alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 data.
REQ-008 alu_src_b  output  2  00 rs2 data, 01 ImmExt, 10 constant 4.
REQ-009 result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-010 adr_src, ir_write, pc_update, branch, reg_write, mem_write  output  1 each  datapath strobes.
REQ-011 pc_write  output  1  equals pc_update OR (branch AND zero), combinational.
REQ-012 state  output  4  current state encoding, for debug.
REQ-013 illegal  output  1  sticky illegal-opcode flag; present only under REQ-031.

Function
REQ-014 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11.
REQ-015 Opcodes decoded: lw 0000011, sw 0100011, R-type 0110011, I-type ALU 0010011, jal 1101111, beq 1100011.
REQ-016 Transitions:
- FETCH to DECODE.
- DECODE: lw/sw to MEMADR; R to EXECR; I to EXECI; jal to JAL; beq to BEQ.
- MEMADR: lw to MEMREAD; sw to MEMWRITE.
- MEMREAD to MEMWB.
- EXECR, EXECI and JAL to ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ to FETCH.
REQ-017 Outputs are a pure Moore decode of state; every signal not listed for a state is 0.
REQ-018 FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10, pc_update 1.
REQ-019 DECODE: alu_src_a 01, alu_src_b 01, alu_op 00.
REQ-020 MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00.
REQ-021 MEMREAD: result_src 00, adr_src 1. MEMWB: result_src 01, reg_write 1.
REQ-022 MEMWRITE: result_src 00, adr_src 1, mem_write 1.
REQ-023 EXECR: alu_src_a 10, alu_src_b 00, alu_op 10. EXECI: alu_src_a 10, alu_src_b 01, alu_op 10.
REQ-024 ALUWB: result_src 00, reg_write 1.
REQ-025 JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update 1.
REQ-026 BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1.
REQ-027 Memory-latency counter (4-bit) applies to FETCH, MEMREAD and MEMWRITE:
- the state is held MEM_LAT cycles; the counter clears on entry and increments each held cycle;
- ir_write, pc_update and mem_write assert only in the final held cycle;
- adr_src and the mux selects hold for all held cycles.
REQ-028 MEM_LAT=1 gives one cycle per state: lw 5 cycles, sw 4, R/I/jal 4, beq 3.
REQ-029 An unrecognised opcode in DECODE (macro absent) returns to FETCH; no strobe asserts in DECODE.

Reset
REQ-030 Reset behaviour:
- a rising clk edge with reset_n=0 loads state FETCH, counter 0 and illegal 0;
- while reset_n=0, reg_write, mem_write, ir_write, pc_update, branch and pc_write are forced 0;
- reset asserted mid-instruction aborts that instruction, with no further strobes.

Configuration
REQ-031 Macro MC_ILLEGAL_TRAP_EN:
- defined: an unrecognised opcode in DECODE goes to TRAP; TRAP holds with all strobes 0; illegal=1 from the cycle after entry until reset.
- undefined: the TRAP state, TRAP handling and the illegal port do not exist; REQ-029 applies.

Verification
REQ-032 add x3,x1,x2 (opcode 0110011), MEM_LAT=1 -> states 0,1,6,7,0; alu_op 10 in EXECR; reg_write=1 only in ALUWB.
REQ-033 lw (0000011), MEM_LAT=3 -> FETCH 3 cycles with ir_write/pc_update only in cycle 3; MEMREAD 3 cycles; then MEMWB with reg_write=1; total 9 cycles.
REQ-034 beq with zero=1, then with zero=0 -> pc_write=1 in BEQ for zero=1 and 0 for zero=0; alu_op 01; next state FETCH in both cases.
REQ-035 sw (0100011) with reset_n driven low in MEMADR -> next state FETCH; mem_write never asserts.
REQ-036 opcode 1111111: macro defined -> state 11, illegal=1, strobes stay 0 for 10 cycles; macro undefined -> DECODE goes to FETCH.

Source files
------------

// File: rtl/mc_main_fsm.sv
// Multicycle RISC-V main control FSM: Moore decode of state, memory states held MEM_LAT cycles.
// Optional illegal-opcode trap (TRAP state + sticky illegal port) under `define MC_ILLEGAL_TRAP_EN.
module mc_main_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write,
  output logic [3:0] state
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    S_TRAP     = 4'd11
`endif
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       held;
  logic       last;

  assign last = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (!reset_n) illegal_q <= 1'b0;
    else if (state_q == S_TRAP) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`endif

  always_comb begin
    state_d = state_q;
    held    = 1'b0;
    case (state_q)
      S_FETCH: begin
        held = 1'b1;
        if (last) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        held = 1'b1;
        if (last) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        held = 1'b1;
        if (last) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI, S_JAL:    state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:    state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:                     state_d = S_TRAP;
`endif
      default:                    state_d = S_FETCH;
    endcase
    // Counter runs only while a memory state is being held; any exit or other state clears it.
    cnt_d = (held && !last) ? cnt_q + 4'd1 : '0;
  end

  always_comb begin
    alu_op     = '0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    result_src = '0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = last;
        pc_update  = last;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = last;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
    // Strobes are suppressed combinationally during reset so an aborted instruction has no side effects.
    if (!reset_n) begin
      ir_write  = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign pc_write = pc_update | (branch & zero);
  assign state    = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm: instance 0 with MEM_LAT=1, instance 1 with MEM_LAT=3.
// Trap checks compile only with `define MC_ILLEGAL_TRAP_EN.
module tb_mc_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic [6:0] opc;
  logic       zin;
  logic       rn [2];
  logic       sel;
  logic [18:0] vec [2];
`ifdef MC_ILLEGAL_TRAP_EN
  logic       ill [2];
`endif

  logic [1:0] alu_op [2], src_a [2], src_b [2], res_src [2];
  logic       adr [2], irw [2], pcu [2], br [2], rw [2], mw [2], pcw [2];
  logic [3:0] st [2];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [18:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mc_main_fsm #(.MEM_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk        (clk),
      .reset_n    (rn[g]),
      .opcode     (opc),
      .zero       (zin),
      .alu_op     (alu_op[g]),
      .alu_src_a  (src_a[g]),
      .alu_src_b  (src_b[g]),
      .result_src (res_src[g]),
      .adr_src    (adr[g]),
      .ir_write   (irw[g]),
      .pc_update  (pcu[g]),
      .branch     (br[g]),
      .reg_write  (rw[g]),
      .mem_write  (mw[g]),
      .pc_write   (pcw[g]),
      .state      (st[g])
`ifdef MC_ILLEGAL_TRAP_EN
      ,
      .illegal    (ill[g])
`endif
    );
    assign vec[g] = {st[g], alu_op[g], src_a[g], src_b[g], res_src[g],
                     adr[g], irw[g], pcu[g], br[g], rw[g], mw[g], pcw[g]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs from the state table: {state, alu_op, src_a, src_b, result_src, adr, irw, pcu, br, rw, mw, pcw}.
  function automatic logic [18:0] exp_vec(input int st_i, input bit last, input bit z, input bit rst);
    logic [1:0] aop, sa, sb, rs;
    logic a, i, p, b, r, m;
    {aop, sa, sb, rs, a, i, p, b, r, m} = '0;
    case (st_i)
      0:  begin sb = 2'b10; rs = 2'b10; i = last; p = last; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  a = 1'b1;
      4:  begin rs = 2'b01; r = 1'b1; end
      5:  begin a = 1'b1; m = last; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  r = 1'b1;
      8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      9:  begin sa = 2'b01; sb = 2'b10; p = 1'b1; end
      10: begin sa = 2'b10; aop = 2'b01; b = 1'b1; end
      default: ;
    endcase
    if (rst) {i, p, b, r, m} = '0;
    return {4'(st_i), aop, sa, sb, rs, a, i, p, b, r, m, p | (b & z)};
  endfunction

  task automatic push_state(input int st_i, input int lat, input bit z);
    int n;
    n = (st_i == 0 || st_i == 3 || st_i == 5) ? lat : 1;
    for (int k = 0; k < n; k++) exp_q.push_back(exp_vec(st_i, k == n - 1, z, 1'b0));
  endtask

  task automatic push_instr(input logic [6:0] op, input int lat, input bit z);
    push_state(0, lat, z);
    push_state(1, lat, z);
    case (op)
      LW:  begin push_state(2, lat, z); push_state(3, lat, z); push_state(4, lat, z); end
      SW:  begin push_state(2, lat, z); push_state(5, lat, z); end
      RT:  begin push_state(6, lat, z); push_state(7, lat, z); end
      IT:  begin push_state(8, lat, z); push_state(7, lat, z); end
      JAL: begin push_state(9, lat, z); push_state(7, lat, z); end
      BEQ: push_state(10, lat, z);
      default: ;
    endcase
  endtask

  // One clock: compare at the falling edge, then return just after the next rising edge.
  task automatic cycle(input string tag);
    logic [18:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(vec[sel]), 32'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input bit z);
    int c;
    opc = op;
    zin = z;
    push_instr(op, sel ? 3 : 1, z);
    c = 0;
    while (exp_q.size() > 0) begin
      cycle($sformatf("%s c%0d", tag, c));
      c++;
    end
  endtask

  initial begin
    rn[0] = 1'b0;
    rn[1] = 1'b0;
    opc   = RT;
    zin   = 1'b1;
    sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // FETCH with final-cycle strobes would fire here if reset did not force them low.
    exp_q.push_back(exp_vec(0, 1'b1, 1'b1, 1'b1));
    cycle("reset lat1");
    sel = 1'b1;
    exp_q.push_back(exp_vec(0, 1'b0, 1'b1, 1'b1));
    cycle("reset lat3");
    sel   = 1'b0;
    rn[0] = 1'b1;

    run_instr("add", RT, 1'b0);
    run_instr("addi", IT, 1'b1);
    run_instr("jal", JAL, 1'b0);
    run_instr("beq_z1", BEQ, 1'b1);
    run_instr("beq_z0", BEQ, 1'b0);
    run_instr("sw", SW, 1'b1);
    run_instr("lw", LW, 1'b0);
`ifndef MC_ILLEGAL_TRAP_EN
    run_instr("bad", BAD, 1'b0);
    run_instr("after_bad", RT, 1'b0);
`endif

    // sw aborted by reset asserted during MEMADR
    opc = SW;
    zin = 1'b0;
    push_state(0, 1, 1'b0);
    push_state(1, 1, 1'b0);
    cycle("sw_abort F");
    cycle("sw_abort D");
    rn[0] = 1'b0;
    exp_q.push_back(exp_vec(2, 1'b1, 1'b0, 1'b1));
    cycle("sw_abort MA");
    exp_q.push_back(exp_vec(0, 1'b1, 1'b0, 1'b1));
    cycle("sw_abort rst");
    rn[0] = 1'b1;
    run_instr("after_abort", RT, 1'b0);

`ifdef MC_ILLEGAL_TRAP_EN
    opc = BAD;
    push_state(0, 1, 1'b0);
    push_state(1, 1, 1'b0);
    cycle("trap F");
    cycle("trap D");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("trap st%0d", k), 32'(vec[0]), {13'd0, 4'd11, 15'd0});
      check_eq($sformatf("trap ill%0d", k), 32'(ill[0]), (k > 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    rn[0] = 1'b0;
    @(posedge clk);
    #1;
    rn[0] = 1'b1;
    @(negedge clk);
    check_eq("trap ill_clr", 32'(ill[0]), 32'd0);
    check_eq("trap st_clr", 32'(st[0]), 32'd0);
    @(posedge clk);
    #1;
    run_instr("after_trap", RT, 1'b0);
`endif

    // MEM_LAT=3 instance
    rn[0] = 1'b0;
    sel   = 1'b1;
    rn[1] = 1'b1;
    run_instr("lw3", LW, 1'b0);
    run_instr("sw3", SW, 1'b0);
    run_instr("add3", RT, 1'b0);
    run_instr("beq3", BEQ, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
